// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between two packet sources, uart_tx_arbiter and the uart_tx byte input.
// Valid/ready: a byte moves on a rising clk edge where valid & ready are both high; while
// valid is high and ready is low the sender holds data and last stable; ready may depend on valid.
interface uart_tx_arbiter_if #(
  parameter int DATA_WIDTH_P = 8
);
  logic [DATA_WIDTH_P-1:0] req0_data_i;
  logic                    req0_valid_i;
  logic                    req0_last_i;
  logic                    req0_ready_o;
  logic [DATA_WIDTH_P-1:0] req1_data_i;
  logic                    req1_valid_i;
  logic                    req1_last_i;
  logic                    req1_ready_o;
  logic [DATA_WIDTH_P-1:0] tx_data_o;
  logic                    tx_valid_o;
  logic                    tx_ready_i;
  logic [1:0]              grant_o;
  logic                    wdog_err_o;
  logic [1:0]              state_dbg_o;

  modport slave (
    input  req0_data_i, req0_valid_i, req0_last_i,
    input  req1_data_i, req1_valid_i, req1_last_i,
    input  tx_ready_i,
    output req0_ready_o, req1_ready_o,
    output tx_data_o, tx_valid_o, grant_o, wdog_err_o, state_dbg_o
  );

  modport master (
    output req0_data_i, req0_valid_i, req0_last_i,
    output req1_data_i, req1_valid_i, req1_last_i,
    output tx_ready_i,
    input  req0_ready_o, req1_ready_o,
    input  tx_data_o, tx_valid_o, grant_o, wdog_err_o, state_dbg_o
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-atomic round-robin arbiter feeding uart_tx through one registered output stage.
// Optional mid-packet stall watchdog is enabled by defining TX_ARB_WATCHDOG_EN.
module uart_tx_arbiter #(
  parameter int DATA_WIDTH_P  = 8,
  parameter int WDOG_CYCLES_P = 1024
) (
  input logic              clk_i,
  input logic              rst_ni,
  uart_tx_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  if (WDOG_CYCLES_P < 2) begin : g_wdog_param_check
    $error("WDOG_CYCLES_P must be at least 2");
  end

  logic [1:0]              state;
  logic [1:0]              state_nxt;
  logic                    last_served;
  logic                    last_served_nxt;
  logic [DATA_WIDTH_P-1:0] tx_data_q;
  logic                    tx_valid_q;
  logic                    out_free;
  logic                    rdy0;
  logic                    rdy1;
  logic                    acc0;
  logic                    acc1;
  logic                    accept;
  logic                    acc_last;
  logic [DATA_WIDTH_P-1:0] acc_data;
  logic                    wdog_fire;

  // The output register can take a new byte when empty or when its byte leaves this cycle.
  assign out_free = !tx_valid_q || bus.tx_ready_i;
  assign rdy0     = (state == OWN0) && out_free;
  assign rdy1     = (state == OWN1) && out_free;
  assign acc0     = bus.req0_valid_i && rdy0;
  assign acc1     = bus.req1_valid_i && rdy1;
  assign accept   = acc0 || acc1;
  assign acc_data = acc1 ? bus.req1_data_i : bus.req0_data_i;
  assign acc_last = acc1 ? bus.req1_last_i : bus.req0_last_i;

`ifdef TX_ARB_WATCHDOG_EN
  localparam int CNT_W = ($clog2(WDOG_CYCLES_P) > 0) ? $clog2(WDOG_CYCLES_P) : 1;

  logic [CNT_W-1:0] stall_cnt;
  logic             own_valid;
  logic             wdog_err_q;

  assign own_valid = (state == OWN1) ? bus.req1_valid_i : bus.req0_valid_i;
  assign wdog_fire = (state != IDLE) && !own_valid &&
                     (stall_cnt == CNT_W'(WDOG_CYCLES_P - 1));

  // Counts only cycles the owner has nothing to offer; a backpressured owner is not stalled.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt  <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_fire;
      if ((state == IDLE) || accept || wdog_fire) begin
        stall_cnt <= '0;
      end else if (!own_valid) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.wdog_err_o = wdog_err_q;
`else
  assign wdog_fire      = 1'b0;
  assign bus.wdog_err_o = 1'b0;
`endif

  always_comb begin
    state_nxt       = state;
    last_served_nxt = last_served;
    case (state)
      IDLE: begin
        if (bus.req0_valid_i && bus.req1_valid_i) begin
          state_nxt = last_served ? OWN0 : OWN1;
        end else if (bus.req0_valid_i) begin
          state_nxt = OWN0;
        end else if (bus.req1_valid_i) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if ((acc0 && acc_last) || wdog_fire) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b0;
        end
      end
      OWN1: begin
        if ((acc1 && acc_last) || wdog_fire) begin
          state_nxt       = IDLE;
          last_served_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      last_served <= 1'b1;
      tx_data_q   <= '0;
      tx_valid_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      last_served <= last_served_nxt;
      if (accept) begin
        tx_data_q  <= acc_data;
        tx_valid_q <= 1'b1;
      end else if (bus.tx_ready_i) begin
        tx_valid_q <= 1'b0;
      end
    end
  end

  assign bus.req0_ready_o = rdy0;
  assign bus.req1_ready_o = rdy1;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.tx_valid_o   = tx_valid_q;
  assign bus.grant_o      = {state == OWN1, state == OWN0};
  assign bus.state_dbg_o  = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: packet drivers, output scoreboard, per-scenario tasks.
module tb_uart_tx_arbiter;

  localparam int W    = 8;
  localparam int WDOG = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  logic [W-1:0] exp_q[$];
  int           out_cyc[$];
  logic [W-1:0] mon_exp;

  uart_tx_arbiter_if #(.DATA_WIDTH_P(W)) bus ();

  uart_tx_arbiter #(
    .DATA_WIDTH_P (W),
    .WDOG_CYCLES_P(WDOG)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // ---------------- scoreboard ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.tx_valid_o && bus.tx_ready_i) begin
        out_cyc.push_back(cyc);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL out_unexpected: got %h, expected no byte", bus.tx_data_o);
        end else begin
          mon_exp = exp_q.pop_front();
          if (bus.tx_data_o !== mon_exp) begin
            n_fail++;
            $display("FAIL out_data: got %h, expected %h", bus.tx_data_o, mon_exp);
          end
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_pkt(input int src, input logic [31:0] bytes, input int len);
    bit ok;
    for (int i = 0; i < len; i++) begin
      if (src == 0) begin
        bus.req0_valid_i = 1'b1;
        bus.req0_data_i  = bytes[8*i +: 8];
        bus.req0_last_i  = (i == len - 1);
      end else begin
        bus.req1_valid_i = 1'b1;
        bus.req1_data_i  = bytes[8*i +: 8];
        bus.req1_last_i  = (i == len - 1);
      end
      ok = 1'b0;
      for (int c = 0; c < 200 && !ok; c++) begin
        @(negedge clk);
        if ((src == 0) ? bus.req0_ready_o : bus.req1_ready_o) ok = 1'b1;
        @(posedge clk); #1;
      end
      n_checks++;
      if (!ok) begin
        n_fail++;
        $display("FAIL accept_timeout: src %0d byte %0d got no ready in 200 cycles, expected accept", src, i);
      end
    end
    if (src == 0) begin
      bus.req0_valid_i = 1'b0;
      bus.req0_last_i  = 1'b0;
    end else begin
      bus.req1_valid_i = 1'b0;
      bus.req1_last_i  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int c = 0; c < 100 && exp_q.size() != 0; c++) @(posedge clk);
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    bus.req0_valid_i = 1'b1; bus.req0_data_i = 8'h5C; bus.req0_last_i = 1'b0;
    bus.req1_valid_i = 1'b0; bus.req1_data_i = '0;    bus.req1_last_i = 1'b0;
    bus.tx_ready_i   = 1'b1;
    repeat (2) @(posedge clk); #1;
    n_checks++; if (bus.tx_valid_o !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_valid: got %b, expected 0", bus.tx_valid_o); end
    n_checks++; if (bus.tx_data_o !== 8'h00)   begin n_fail++; $display("FAIL reset_tx_data: got %h, expected 00", bus.tx_data_o); end
    n_checks++; if (bus.grant_o !== 2'b00)     begin n_fail++; $display("FAIL reset_grant: got %b, expected 00", bus.grant_o); end
    n_checks++; if (bus.req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b, expected 0", bus.req0_ready_o); end
    n_checks++; if (bus.req1_ready_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready1: got %b, expected 0", bus.req1_ready_o); end
    n_checks++; if (bus.wdog_err_o !== 1'b0)   begin n_fail++; $display("FAIL reset_wdog: got %b, expected 0", bus.wdog_err_o); end
    n_checks++; if (bus.state_dbg_o !== 2'd0)  begin n_fail++; $display("FAIL reset_state: got %0d, expected 0", bus.state_dbg_o); end
    bus.req0_valid_i = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.grant_o !== 2'b00) begin n_fail++; $display("FAIL idle_grant: got %b, expected 00", bus.grant_o); end
    @(posedge clk); #1;
  endtask

  task automatic test_single_packet();
    logic [7:0] ed[3];
    logic [1:0] eg[3];
    int         waited;
    ed = '{8'h11, 8'h22, 8'h33};
    eg = '{2'b01, 2'b01, 2'b00};
    waited = 0;
    for (int k = 0; k < 3; k++) exp_q.push_back(ed[k]);
    fork
      send_pkt(0, 32'h0033_2211, 3);
      begin
        while (!bus.tx_valid_o && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        n_checks++;
        if (waited !== 3) begin n_fail++; $display("FAIL single_latency: got first byte at negedge %0d, expected 3", waited); end
        for (int k = 0; k < 3; k++) begin
          if (k > 0) @(negedge clk);
          n_checks++;
          if (bus.tx_data_o !== ed[k] || bus.tx_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL single_data[%0d]: got %h valid %b, expected %h valid 1", k, bus.tx_data_o, bus.tx_valid_o, ed[k]);
          end
          n_checks++;
          if (bus.grant_o !== eg[k]) begin n_fail++; $display("FAIL single_grant[%0d]: got %b, expected %b", k, bus.grant_o, eg[k]); end
        end
      end
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL single_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_priority();
    apply_reset();
    out_cyc.delete();
    exp_q.push_back(8'h21); exp_q.push_back(8'h22);
    exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
    fork
      send_pkt(0, 32'h0000_2221, 2);
      send_pkt(1, 32'h0000_A2A1, 2);
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL priority_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
    n_checks++;
    if (out_cyc.size() != 4) begin
      n_fail++; $display("FAIL priority_count: got %0d output bytes, expected 4", out_cyc.size());
    end else if (out_cyc[2] - out_cyc[1] != 2) begin
      n_fail++; $display("FAIL priority_bubble: packet gap %0d cycles, expected 2", out_cyc[2] - out_cyc[1]);
    end
  endtask

  task automatic test_alternate();
    out_cyc.delete();
    for (int p = 0; p < 3; p++) begin
      exp_q.push_back(8'(8'h40 + 2*p)); exp_q.push_back(8'(8'h41 + 2*p));
      exp_q.push_back(8'(8'hC0 + 2*p)); exp_q.push_back(8'(8'hC1 + 2*p));
    end
    fork
      begin
        for (int p = 0; p < 3; p++) send_pkt(0, {16'h0, 8'(8'h41 + 2*p), 8'(8'h40 + 2*p)}, 2);
      end
      begin
        for (int p = 0; p < 3; p++) send_pkt(1, {16'h0, 8'(8'hC1 + 2*p), 8'(8'hC0 + 2*p)}, 2);
      end
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL alt_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
    n_checks++;
    if (out_cyc.size() != 12) begin
      n_fail++; $display("FAIL alt_count: got %0d output bytes, expected 12", out_cyc.size());
    end else begin
      for (int i = 1; i < 12; i++) begin
        n_checks++;
        if (out_cyc[i] - out_cyc[i-1] != ((i % 2 == 1) ? 1 : 2)) begin
          n_fail++; $display("FAIL alt_spacing[%0d]: gap %0d, expected %0d", i, out_cyc[i] - out_cyc[i-1], (i % 2 == 1) ? 1 : 2);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int waited;
    waited = 0;
    bus.tx_ready_i = 1'b0;
    exp_q.push_back(8'hA5); exp_q.push_back(8'h5A);
    fork
      send_pkt(0, 32'h0000_5AA5, 2);
      begin
        while (!bus.tx_valid_o && waited < 20) begin
          @(negedge clk);
          waited++;
        end
        n_checks++;
        if (bus.tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got valid %b, expected 1", bus.tx_valid_o); end
        for (int k = 0; k < 5; k++) begin
          if (k > 0) @(negedge clk);
          n_checks++;
          if (bus.tx_data_o !== 8'hA5 || bus.tx_valid_o !== 1'b1) begin
            n_fail++; $display("FAIL bp_hold[%0d]: got %h valid %b, expected A5 valid 1", k, bus.tx_data_o, bus.tx_valid_o);
          end
          n_checks++;
          if (bus.req0_ready_o !== 1'b0 || bus.req1_ready_o !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready[%0d]: got %b%b, expected 00", k, bus.req1_ready_o, bus.req0_ready_o);
          end
        end
        @(posedge clk); #1;
        bus.tx_ready_i = 1'b1;
      end
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL bp_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic test_reset_mid_packet();
    exp_q.push_back(8'hC1);
    bus.req0_valid_i = 1'b1; bus.req0_data_i = 8'hC1; bus.req0_last_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.req0_data_i = 8'hC2;
    @(posedge clk); #1;
    // C2 now sits in the output register, held there by backpressure when reset hits.
    bus.req0_data_i = 8'hC3;
    bus.tx_ready_i  = 1'b0;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (bus.tx_valid_o !== 1'b0)   begin n_fail++; $display("FAIL rst_mid_valid: got %b, expected 0", bus.tx_valid_o); end
    n_checks++; if (bus.tx_data_o !== 8'h00)   begin n_fail++; $display("FAIL rst_mid_data: got %h, expected 00", bus.tx_data_o); end
    n_checks++; if (bus.grant_o !== 2'b00)     begin n_fail++; $display("FAIL rst_mid_grant: got %b, expected 00", bus.grant_o); end
    n_checks++; if (bus.req0_ready_o !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ready0: got %b, expected 0", bus.req0_ready_o); end
    n_checks++; if (bus.state_dbg_o !== 2'd0)  begin n_fail++; $display("FAIL rst_mid_state: got %0d, expected 0", bus.state_dbg_o); end
    n_checks++; if (exp_q.size() != 0)         begin n_fail++; $display("FAIL rst_mid_sent: %0d bytes missing, expected 0", exp_q.size()); exp_q.delete(); end
    bus.req0_valid_i = 1'b0;
    bus.tx_ready_i   = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.push_back(8'h71); exp_q.push_back(8'h81);
    fork
      send_pkt(0, 32'h0000_0071, 1);
      send_pkt(1, 32'h0000_0081, 1);
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL rst_mid_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
  endtask

  task automatic start_stalled_req1();
    bit ok;
    apply_reset();
    exp_q.push_back(8'hE1);
    bus.req1_valid_i = 1'b1; bus.req1_data_i = 8'hE1; bus.req1_last_i = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 10 && !ok; c++) begin
      @(negedge clk);
      if (bus.req1_ready_o) ok = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL stall_first_accept: got no ready1, expected accept"); end
    bus.req1_valid_i = 1'b0;
  endtask

`ifdef TX_ARB_WATCHDOG_EN
  task automatic test_watchdog();
    logic       exp_w;
    logic [1:0] exp_g;
    start_stalled_req1();
    exp_q.push_back(8'h0D);
    bus.req0_valid_i = 1'b1; bus.req0_data_i = 8'h0D; bus.req0_last_i = 1'b1;
    for (int s = 1; s <= WDOG + 2; s++) begin
      @(negedge clk);
      exp_w = (s == WDOG + 1);
      exp_g = (s <= WDOG) ? 2'b10 : ((s == WDOG + 1) ? 2'b00 : 2'b01);
      n_checks++;
      if (bus.wdog_err_o !== exp_w) begin n_fail++; $display("FAIL wdog_err[%0d]: got %b, expected %b", s, bus.wdog_err_o, exp_w); end
      n_checks++;
      if (bus.grant_o !== exp_g) begin n_fail++; $display("FAIL wdog_grant[%0d]: got %b, expected %b", s, bus.grant_o, exp_g); end
      @(posedge clk); #1;
    end
    bus.req0_valid_i = 1'b0; bus.req0_last_i = 1'b0;
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL wdog_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
  endtask
`else
  task automatic test_hold_ownership();
    start_stalled_req1();
    bus.req0_valid_i = 1'b1; bus.req0_data_i = 8'h0D; bus.req0_last_i = 1'b1;
    for (int s = 0; s < 3 * WDOG; s++) begin
      @(negedge clk);
      n_checks++;
      if (bus.grant_o !== 2'b10 || bus.req0_ready_o !== 1'b0 || bus.wdog_err_o !== 1'b0) begin
        n_fail++; $display("FAIL hold[%0d]: got grant %b ready0 %b wdog %b, expected 10 0 0", s, bus.grant_o, bus.req0_ready_o, bus.wdog_err_o);
      end
      @(posedge clk); #1;
    end
    exp_q.push_back(8'hE2); exp_q.push_back(8'h0D);
    fork
      send_pkt(1, 32'h0000_00E2, 1);
      send_pkt(0, 32'h0000_000D, 1);
    join
    wait_drain();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL hold_drain: %0d bytes left, expected 0", exp_q.size()); exp_q.delete(); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_packet();
    test_priority();
    test_alternate();
    test_backpressure();
    test_reset_mid_packet();
`ifdef TX_ARB_WATCHDOG_EN
    test_watchdog();
`else
    test_hold_ownership();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at 200000, expected completion");
    $fatal(1, "time limit reached");
  end

endmodule
